// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the writeback-stage memory port. It accepts one
// load or store at a time. After a fixed number of wait states it commits the
// access and produces a one-cycle response. RV32I byte, half and word accesses
// are supported, with sign or zero extension on loads. Misaligned or illegal
// accesses are flagged and have no side effect on storage.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   MemWriteW   store request (wins if MemReadW is also high)
//   MemReadW    load request
//   AddrW       byte address; upper bits beyond the storage size alias
//   WriteDataW  store data, right-aligned
//   funct3W     000 B, 001 H, 010 W, 100 BU, 101 HU
//   ReadDataW   extended load data, non-zero only in the response cycle
//   MemValidW   one-cycle response pulse
//   MemBusyW    stall request, high from acceptance until the response cycle
//   AccessErrW  illegal-access flag, coincident with MemValidW
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteW,
    input  logic        MemReadW,
    input  logic [31:0] AddrW,
    input  logic [31:0] WriteDataW,
    input  logic [2:0]  funct3W,
    output logic [31:0] ReadDataW,
    output logic        MemValidW,
    output logic        MemBusyW,
    output logic        AccessErrW
);

    localparam int         AW   = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT4 = 4'(LATENCY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    f3_q, f3_d;
    logic          store_q, store_d;

    logic          illegal;
    logic          commit;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [AW-1:0] idx;
    logic [31:0]   raw_word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;
    logic          unused_addr;

    assign idx         = addr_q[AW+1:2];
    assign unused_addr = ^addr_q[31:AW+2];

    // ------------------------------------------------------------------
    // Request latching and sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        store_d = store_q;
        case (state_q)
            S_IDLE: begin
                if (MemReadW || MemWriteW) begin
                    addr_d  = AddrW;
                    wdata_d = WriteDataW;
                    f3_d    = funct3W;
                    store_d = MemWriteW;
                    cnt_d   = LAT4;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            store_q <= store_d;
        end
    end

    // ------------------------------------------------------------------
    // Access legality, evaluated on the latched request
    // ------------------------------------------------------------------
    always_comb begin
        illegal = 1'b0;
        case (f3_q)
            3'b000, 3'b100: illegal = 1'b0;
            3'b001, 3'b101: illegal = addr_q[0];
            3'b010:         illegal = (addr_q[1:0] != 2'b00);
            default:        illegal = 1'b1;
        endcase
        // Unsigned variants have no meaning for stores.
        if (store_q && f3_q[2]) begin
            illegal = 1'b1;
        end
    end

    // The access happens on the edge that leaves WAIT. A reset before that
    // edge drops the state to IDLE asynchronously, so the write never fires.
    assign commit = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign we     = commit && store_q && !illegal;

    // Store data is replicated across lanes so each lane only needs its own
    // enable bit.
    always_comb begin
        be    = 4'b1111;
        wlane = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_q[1:0];
                wlane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: one byte-wide RAM per lane with a registered read. Contents
    // are deliberately not reset.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    lane_mem[idx] <= wlane[8*gi +: 8];
                end
                if (commit) begin
                    rd_q <= lane_mem[idx];
                end
            end
        end
    endgenerate

    assign raw_word = {g_lane[3].rd_q, g_lane[2].rd_q, g_lane[1].rd_q, g_lane[0].rd_q};

    // ------------------------------------------------------------------
    // Load alignment and extension
    // ------------------------------------------------------------------
    always_comb begin
        case (addr_q[1:0])
            2'b00:   byte_sel = raw_word[7:0];
            2'b01:   byte_sel = raw_word[15:8];
            2'b10:   byte_sel = raw_word[23:16];
            default: byte_sel = raw_word[31:24];
        endcase
        half_sel = addr_q[1] ? raw_word[31:16] : raw_word[15:0];
        case (f3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'd0, half_sel};
            3'b010:  load_data = raw_word;
            default: load_data = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign MemValidW  = (state_q == S_RESP);
    assign AccessErrW = (state_q == S_RESP) && illegal;
    assign ReadDataW  = ((state_q == S_RESP) && !store_q && !illegal) ? load_data : 32'd0;

    // Busy covers the acceptance cycle combinationally. It is forced low while
    // reset is held so that every output reads zero during reset.
    assign MemBusyW = !reset &&
                      (((state_q == S_IDLE) && (MemReadW || MemWriteW)) ||
                       (state_q == S_WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_wr  [3];
    logic        req_rd  [3];
    logic [31:0] req_a   [3];
    logic [31:0] req_d   [3];
    logic [2:0]  req_f3  [3];
    logic [31:0] o_rd    [3];
    logic        o_valid [3];
    logic        o_busy  [3];
    logic        o_err   [3];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // ---------------- reference rules ----------------
    function automatic bit illegal_f(input bit w, input logic [31:0] a, input logic [2:0] f3);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        if (w && f3 >= 4)                  return 1'b1;
        if ((f3 == 1 || f3 == 5) && (a % 2) != 0) return 1'b1;
        if (f3 == 2 && (a % 4) != 0)       return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] load_f(input logic [31:0] word, input logic [31:0] a,
                                           input logic [2:0] f3);
        logic [31:0] v;
        v = word >> (8 * (a % 4));
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 128)   v = v | 32'hFFFF_FF00; end
            3'd4: v = v & 32'hFF;
            3'd1: begin v = v & 32'hFFFF; if (v >= 32768) v = v | 32'hFFFF_0000; end
            3'd5: v = v & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] store_f(input logic [31:0] word, input logic [31:0] a,
                                            input logic [31:0] d, input logic [2:0] f3);
        int size;
        int lane;
        logic [31:0] w;
        w    = word;
        size = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
        for (int b = 0; b < size; b++) begin
            lane = int'(a % 4) + b;
            w = (w & ~(32'hFF << (8 * lane))) | (((d >> (8 * b)) & 32'hFF) << (8 * lane));
        end
        return w;
    endfunction

    // ---------------- DUTs + per-DUT model/compare ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 1 : (gi == 1) ? 0 : 3;

            dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) u_dut (
                .clk        (clk),
                .reset      (reset),
                .MemWriteW  (req_wr[gi]),
                .MemReadW   (req_rd[gi]),
                .AddrW      (req_a[gi]),
                .WriteDataW (req_d[gi]),
                .funct3W    (req_f3[gi]),
                .ReadDataW  (o_rd[gi]),
                .MemValidW  (o_valid[gi]),
                .MemBusyW   (o_busy[gi]),
                .AccessErrW (o_err[gi])
            );

            int          since = -1;   // cycles since acceptance, -1 when idle
            bit          m_w;
            logic [31:0] m_a, m_d;
            logic [2:0]  m_f3;
            logic [31:0] mem_m   [1024];
            bit          known_m [1024];

            always @(negedge clk) begin : model_cmp
                logic [31:0] e_rd;
                logic        e_v, e_b, e_e;
                bit          chk_data;
                int          idx;
                e_rd = 0; e_v = 0; e_b = 0; e_e = 0; chk_data = 1;
                if (reset) begin
                    since = -1;
                end else if (since < 0) begin
                    if (req_wr[gi] || req_rd[gi]) begin
                        e_b  = 1;
                        m_w  = req_wr[gi];
                        m_a  = req_a[gi];
                        m_d  = req_d[gi];
                        m_f3 = req_f3[gi];
                        since = 0;
                    end
                end else begin
                    since++;
                    if (since <= LAT + 1) begin
                        e_b = 1;
                    end else begin
                        e_v = 1;
                        idx = int'((m_a >> 2) % 1024);
                        e_e = illegal_f(m_w, m_a, m_f3);
                        if (!e_e && m_w) begin
                            mem_m[idx]   = store_f(mem_m[idx], m_a, m_d, m_f3);
                            known_m[idx] = 1;
                        end else if (!e_e) begin
                            e_rd     = load_f(mem_m[idx], m_a, m_f3);
                            chk_data = known_m[idx];
                        end
                        since = -1;
                    end
                end
                n_cmp++;
                if (o_busy[gi] !== e_b || o_valid[gi] !== e_v || o_err[gi] !== e_e ||
                    (chk_data && o_rd[gi] !== e_rd)) begin
                    n_fail++;
                    $display("FAIL cycle_dut%0d t=%0t got busy=%b valid=%b err=%b rd=%h want busy=%b valid=%b err=%b rd=%h",
                             gi, $time, o_busy[gi], o_valid[gi], o_err[gi], o_rd[gi], e_b, e_v, e_e, e_rd);
                end
            end
        end
    endgenerate

    // ---------------- driver and literal checks ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_txn(input int k, input bit w, input bit r, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f3,
                          output logic [31:0] rdo, output logic erro, output int lat);
        bit got;
        @(posedge clk); #1;
        req_wr[k] = w; req_rd[k] = r; req_a[k] = a; req_d[k] = d; req_f3[k] = f3;
        @(posedge clk); #1;
        req_wr[k] = 0; req_rd[k] = 0; req_a[k] = $urandom; req_d[k] = $urandom;
        req_f3[k] = 3'($urandom);
        rdo = 0; erro = 0; lat = 0; got = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (o_valid[k]) begin
                got = 1; lat = c; rdo = o_rd[k]; erro = o_err[k];
            end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout dut%0d got no MemValidW want pulse within 40 cycles", k);
        end
    endtask

    logic [31:0] rdv;
    logic        ev;
    int          lt;

    initial begin
        reset = 1;
        for (int k = 0; k < 3; k++) begin
            req_wr[k] = 0; req_rd[k] = 0; req_a[k] = 0; req_d[k] = 0; req_f3[k] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(o_valid[0]), 0);
        chk("reset_busy",  32'(o_busy[0]),  0);
        chk("reset_rdata", o_rd[0], 0);
        @(posedge clk); #1 reset = 0;

        // Prefill the first 16 words of every instance; word 8 (0x20) holds 0.
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++)
                do_txn(k, 1, 0, 32'(i * 4), (i == 8) ? 32'd0 : $urandom, 3'b010, rdv, ev, lt);

        // Word round trip and latency.
        do_txn(0, 1, 0, 32'h10, 32'hDEADBEEF, 3'b010, rdv, ev, lt);
        do_txn(0, 0, 1, 32'h10, 32'h0, 3'b010, rdv, ev, lt);
        chk("lw_deadbeef", rdv, 32'hDEADBEEF);
        chk("lw_err", 32'(ev), 0);
        chk("lat1", 32'(lt), 3);

        // Extension.
        do_txn(0, 1, 0, 32'h10, 32'h80FF7F01, 3'b010, rdv, ev, lt);
        do_txn(0, 0, 1, 32'h13, 0, 3'b000, rdv, ev, lt); chk("lb_13",  rdv, 32'hFFFFFF80);
        do_txn(0, 0, 1, 32'h13, 0, 3'b100, rdv, ev, lt); chk("lbu_13", rdv, 32'h00000080);
        do_txn(0, 0, 1, 32'h12, 0, 3'b001, rdv, ev, lt); chk("lh_12",  rdv, 32'hFFFF80FF);
        do_txn(0, 0, 1, 32'h10, 0, 3'b101, rdv, ev, lt); chk("lhu_10", rdv, 32'h00007F01);

        // Sub-word stores.
        do_txn(0, 1, 0, 32'h10, 32'h11223344, 3'b010, rdv, ev, lt);
        do_txn(0, 1, 0, 32'h11, 32'hFFFFFFAA, 3'b000, rdv, ev, lt);
        do_txn(0, 0, 1, 32'h10, 0, 3'b010, rdv, ev, lt); chk("sb_merge", rdv, 32'h1122AA44);
        do_txn(0, 1, 0, 32'h12, 32'h00005566, 3'b001, rdv, ev, lt);
        do_txn(0, 0, 1, 32'h10, 0, 3'b010, rdv, ev, lt); chk("sh_merge", rdv, 32'h5566AA44);

        // Illegal accesses; storage must be untouched.
        do_txn(0, 0, 1, 32'h12, 0, 3'b010, rdv, ev, lt);
        chk("lw_mis_err", 32'(ev), 1); chk("lw_mis_rd", rdv, 0);
        do_txn(0, 1, 0, 32'h13, 32'h0000BEEF, 3'b001, rdv, ev, lt);
        chk("sh_mis_err", 32'(ev), 1);
        do_txn(0, 0, 1, 32'h10, 0, 3'b010, rdv, ev, lt); chk("mis_unchanged", rdv, 32'h5566AA44);

        // Aliasing of upper address bits.
        do_txn(0, 1, 0, 32'h1000, 32'hCAFEF00D, 3'b010, rdv, ev, lt);
        do_txn(0, 0, 1, 32'h0, 0, 3'b010, rdv, ev, lt); chk("alias_w0", rdv, 32'hCAFEF00D);

        // Latency of the other two instances.
        do_txn(1, 0, 1, 32'h10, 0, 3'b010, rdv, ev, lt); chk("lat0", 32'(lt), 2);
        do_txn(2, 0, 1, 32'h10, 0, 3'b010, rdv, ev, lt); chk("lat3", 32'(lt), 5);

        // Reset during WAIT of a store: store must be dropped.
        @(posedge clk); #1;
        req_wr[0] = 1; req_a[0] = 32'h20; req_d[0] = 32'h12345678; req_f3[0] = 3'b010;
        @(posedge clk); #1;
        req_wr[0] = 0; reset = 1;
        #1;
        chk("rst_busy",  32'(o_busy[0]),  0);
        chk("rst_valid", 32'(o_valid[0]), 0);
        chk("rst_rdata", o_rd[0], 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        do_txn(0, 0, 1, 32'h20, 0, 3'b010, rdv, ev, lt); chk("rst_no_write", rdv, 32'h0);

        // Randomized traffic, checked every cycle by the model.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 120; n++) begin
                int op;
                op = $urandom_range(1, 3);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                do_txn(k, op[1], op[0], ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)),
                       $urandom, 3'($urandom_range(0, 7)), rdv, ev, lt);
            end
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
